// File: rtl/up_down_pkg.sv
// rtl/up_down_pkg.sv - shared default width for the up/down counter
package up_down_pkg;
  localparam int COUNTER_WIDTH = 4;
endpackage

// File: rtl/up_down.sv
// rtl/up_down.sv - loadable binary up/down counter with terminal-count flag
module up_down
  import up_down_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic             upordown,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  logic [WIDTH-1:0] count_next;
  logic             at_top;
  logic             at_bottom;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = data_in;
    end else if (enable) begin
      count_next = upordown ? count + 1'b1 : count - 1'b1;
    end

    at_top    = (count == ALL_ONES);
    at_bottom = (count == ALL_ZERO);
    // Gated by rst so the flag stays low while the count is held at zero in reset.
    tc = rst & enable & ~load & ((upordown & at_top) | (~upordown & at_bottom));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_up_down.sv
// tb/tb_up_down.sv - self-checking bench for the up/down counter
module tb_up_down;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load;
  logic         upordown;
  logic [W-1:0] data_in;
  logic [W-1:0] count;
  logic         tc;

  int n_tests = 0;
  int n_fail  = 0;
  int model   = 0;

  typedef struct {
    logic         en;
    logic         ld;
    logic         ud;
    logic [W-1:0] din;
    int           exp_count;
    logic         exp_tc;
  } vec_t;

  vec_t vecs[$];

  up_down #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .load     (load),
    .upordown (upordown),
    .data_in  (data_in),
    .count    (count),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  function automatic int model_next(int c, logic en, logic ld, logic ud, logic [W-1:0] din);
    if (ld) return int'(din);
    if (!en) return c;
    return ud ? (c + 1) % MOD : (c + MOD - 1) % MOD;
  endfunction

  // Terminal count: the next enabled step leaves the range [0, MOD).
  function automatic logic model_tc(int c, logic en, logic ld, logic ud);
    if (!en || ld) return 1'b0;
    return ud ? (c + 1 >= MOD) : (c - 1 < 0);
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(logic en, logic ld, logic ud, logic [W-1:0] din, string tag);
    enable = en; load = ld; upordown = ud; data_in = din;
    @(negedge clk);
    check({tag, " tc"}, int'(tc), int'(model_tc(model, en, ld, ud)));
    @(posedge clk); #1;
    model = model_next(model, en, ld, ud, din);
    check({tag, " count"}, int'(count), model);
  endtask

  task automatic apply_vec(vec_t v, int idx);
    enable = v.en; load = v.ld; upordown = v.ud; data_in = v.din;
    @(negedge clk);
    check($sformatf("vec%0d tc", idx), int'(tc), int'(v.exp_tc));
    @(posedge clk); #1;
    model = model_next(model, v.en, v.ld, v.ud, v.din);
    check($sformatf("vec%0d count", idx), int'(count), v.exp_count);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; load = 1'b0; upordown = 1'b0; data_in = '0;
    #1;
    check("reset count", int'(count), 0);
    check("reset tc masked", int'(tc), 0);
    enable = 1'b0;
    #2 rst = 1'b1;
    model = 0;
    @(posedge clk); #1;
    check("first edge hold", int'(count), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, i[0], 4'h0, "hold");

    for (int i = 0; i < 20; i++)
      vecs.push_back('{1'b1, 1'b0, 1'b1, 4'h0, (i + 1) % 16, (i % 16) == 15});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'hA, 10, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0,  9, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0,  8, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0,  7, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'h1,  1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0,  0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 15, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'h0,  0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'h0,  1, 1'b0});
    for (int i = 0; i < 10; i++)
      vecs.push_back('{1'b0, 1'b0, i[0], 4'hF, 1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'h0,  2, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 15, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 4'h0,  0, 1'b1});

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Asynchronous reset between edges, with a pending load that must be dropped.
    step(1'b1, 1'b1, 1'b0, 4'h5, "preload");
    enable = 1'b0; load = 1'b0;
    #2;
    rst = 1'b0; enable = 1'b1; upordown = 1'b0; load = 1'b1; data_in = 4'h9;
    #1;
    check("async clr count", int'(count), 0);
    check("async clr tc", int'(tc), 0);
    @(posedge clk); #1;
    check("reset discards load", int'(count), 0);
    #2;
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    model = 0;
    for (int i = 0; i < 5; i++) begin
      #5;
      check("post reset hold", int'(count), 0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
           W'($urandom_range(0, MOD - 1)), "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/up_down.md
Name: up_down

Overview:
- Synchronous, loadable, binary up/down counter with a parameterised width; default is 4 bits.
- Count direction is selected per cycle. A parallel load presets the count, and an enable freezes or advances it.
- General-purpose leaf block for sequencing, address stepping and timeout logic inside larger datapaths.

Parameters:
- WIDTH, 4, counter width in bits (legal range ≥ 2).

Ports:
- clk  input  1  rising-edge clock; all state changes except reset occur on this edge.
- rst  input  1  asynchronous reset, active-low; 0 forces count to zero immediately.
- enable  input  1  count enable; 1 allows count to step on each rising clk edge.
- load  input  1  synchronous parallel load; 1 captures data_in on the next rising clk edge.
- upordown  input  1  direction; 1 counts up, 0 counts down.
- data_in  input  WIDTH  preset value used when load=1.
- count  output  WIDTH  registered counter value.
- tc  output  1  terminal-count flag (combinational): next enabled step will wrap.

Behaviour:
- Reset: rst=0 asynchronously clears count to all zeros, independent of clk. count holds zero while rst=0. Normal operation resumes on the first rising clk edge after rst returns to 1.
- Priority at each rising clk edge (rst=1), highest first:
  1. load=1: count <= data_in. Load does not depend on enable or upordown.
  2. enable=1, upordown=1: count <= count + 1, modulo 2^WIDTH.
  3. enable=1, upordown=0: count <= count - 1, modulo 2^WIDTH.
  4. Otherwise: count holds.
- Latency: one clock from a sampled control/data input to the updated count. No combinational path from inputs to count.
- Wrap-around:
  - Up from all-ones gives zero (4-bit: 1111 -> 0000).
  - Down from zero gives all-ones (0000 -> 1111).
  - No saturation.
- tc:
  - tc = enable & ~load & ((upordown & count==all-ones) | (~upordown & count==0)).
  - tc is 0 while rst=0.
- Direction change takes effect on the first clock edge that samples the new upordown value. No extra delay, no skipped or repeated value.
- Simultaneous load and enable: load wins; the loaded value is not also incremented or decremented that cycle.
- Reset mid-operation:
  - Asserting rst at any time, including between clock edges, clears count without waiting for clk.
  - Any pending load or count step is discarded.
- upordown and data_in are don't-care when their controlling signal (enable, load) is 0.
- An X on upordown while enable=1 is not required to be handled; the bench drives it known before enabling.

Decomposition:
- Shared package holds nothing beyond the default width constant (e.g. a COUNTER_WIDTH default). No typedefs required.
- Single module with no sub-modules. Next-state mux and terminal-count decode live in one combinational block feeding one asynchronously reset register.

Test Plan:
- Reset/hold: rst=0 for the first half clock, then rst=1 with enable=0 -> count=0000 throughout, tc=0.
- Up count with wrap: enable=1, upordown=1, 20 clocks from 0000 -> 0001, 0010, ..., 1111 (tc=1 in that cycle), 0000, 0001, ..., 0100.
- Async reset mid-count: count=0101, enable=0, pull rst low between clock edges -> count becomes 0000 before the next rising edge. It stays 0000 for 25 ns after rst returns high, while enable=0.
- Load then down count: enable=1, load=1, upordown=0, data_in=1010 for one edge -> count=1010. Release load; next edges give 1001, 1000, 0111. Load must not also decrement in its own cycle.
- Direction switch and down wrap:
  - Preload 0001, upordown=0 -> 0000 (tc=1), then 1111.
  - Switch upordown=1 -> 0000, 0001. No skipped value on the direction change.
- Disable freeze: mid-count set enable=0 -> count holds its last value for 10 clocks, tc=0. Re-enable resumes from that value.
